// File: rtl/rf_pkg.sv
// Shared definitions for the register bank: address-width helper, R0 index, read-source select.
// Pure declarations; no logic, no latency.
// No flow control; consumed by reg_file_bank and rf_read_port.
package rf_pkg;

  // Index of the register that can be hardwired to zero / used as the BA base.
  localparam int RF_R0 = 0;

  // Where a read port takes its value from this cycle.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_BYPASS,
    SRC_ARRAY
  } rd_src_e;

  // Address width for a bank of 'depth' registers (depth is a power of two).
  function automatic int rf_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: zero/bypass/array priority select plus optional registered-read stage.
// Latency 0 (READ_REG=0) or 1 cycle (READ_REG=1, advances only when re is high).
// No backpressure; with READ_REG=1, re low simply holds the last captured value.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AW       = 4,
  parameter bit R0_ZERO  = 1'b0,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [AW-1:0]    raddr,
  input  logic             ba_mode,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] arr_data,
  input  logic             re,
  output logic [WIDTH-1:0] rdata
);

  rd_src_e          src;
  logic [WIDTH-1:0] rd_val;
  logic             r0_hit;
  logic             w_r0_drop;

  assign r0_hit    = (raddr == AW'(RF_R0));
  // A write to R0 in hardwired-zero mode never lands, so it must not be forwarded.
  assign w_r0_drop = R0_ZERO && (waddr == AW'(RF_R0));

  // Pick the read source: BA zero first, then hardwired R0, then bypass, then storage.
  always_comb begin
    src = SRC_ARRAY;
    if (ba_mode && r0_hit) begin
      src = SRC_ZERO;
    end else if (R0_ZERO && r0_hit) begin
      src = SRC_ZERO;
    end else if (BYPASS && we && (raddr == waddr) && !w_r0_drop) begin
      src = SRC_BYPASS;
    end
  end

  // Data mux driven by the selected source.
  always_comb begin
    rd_val = arr_data;
    case (src)
      SRC_ZERO:   rd_val = '0;
      SRC_BYPASS: rd_val = wdata;
      SRC_ARRAY:  rd_val = arr_data;
      default:    rd_val = arr_data;
    endcase
  end

  if (READ_REG) begin : g_reg
    logic [WIDTH-1:0] rdata_q;

    // Registered read: clear wins over re, re low holds the previous value.
    always_ff @(posedge clk) begin
      if (clr) begin
        rdata_q <= '0;
      end else if (re) begin
        rdata_q <= rd_val;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_comb
    // Combinational read path; the stage controls are intentionally unused here.
    logic unused_stage;
    assign unused_stage = ^{clk, clr, re};
    assign rdata        = rd_val;
  end

endmodule

// File: rtl/reg_file_bank.sv
// DEPTH x WIDTH register bank: one synchronous write port, two read ports (A with BA mode, B).
// Write lands at the rising edge; reads have 0 or 1 cycle latency depending on READ_REG.
// No backpressure; every write and read is accepted in the cycle it is presented.
module reg_file_bank
  import rf_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               R0_ZERO   = 1'b0,
  parameter bit               BYPASS    = 1'b1,
  parameter bit               READ_REG  = 1'b0,
  localparam int              AW        = rf_addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             ba_mode,
  input  logic             re,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] arr_a;
  logic [WIDTH-1:0] arr_b;

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    // R0 in hardwired-zero mode resets to zero and ignores writes.
    localparam bit               IS_ZERO_REG = R0_ZERO && (g == RF_R0);
    localparam logic [WIDTH-1:0] INIT_VAL    = IS_ZERO_REG ? '0 : RESET_VAL;

    logic [WIDTH-1:0] q;
    logic             wr_en;

    assign wr_en = we && (waddr == AW'(g)) && !IS_ZERO_REG;

    // Per-register storage: clear beats write.
    always_ff @(posedge clk) begin
      if (clr) begin
        q <= INIT_VAL;
      end else if (wr_en) begin
        q <= wdata;
      end
    end

    assign mem[g] = q;
  end

  assign arr_a = mem[raddr_a];
  assign arr_b = mem[raddr_b];

  rf_read_port #(
    .WIDTH    (WIDTH),
    .AW       (AW),
    .R0_ZERO  (R0_ZERO),
    .BYPASS   (BYPASS),
    .READ_REG (READ_REG)
  ) u_port_a (
    .clk      (clk),
    .clr      (clr),
    .raddr    (raddr_a),
    .ba_mode  (ba_mode),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .arr_data (arr_a),
    .re       (re),
    .rdata    (rdata_a)
  );

  // Port B never uses BA addressing.
  rf_read_port #(
    .WIDTH    (WIDTH),
    .AW       (AW),
    .R0_ZERO  (R0_ZERO),
    .BYPASS   (BYPASS),
    .READ_REG (READ_REG)
  ) u_port_b (
    .clk      (clk),
    .clr      (clr),
    .raddr    (raddr_b),
    .ba_mode  (1'b0),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .arr_data (arr_b),
    .re       (re),
    .rdata    (rdata_b)
  );

endmodule

// File: tb/tb_reg_file_bank.sv
// Bench for reg_file_bank: four configurations driven by shared stimulus.
// Each cycle compares every read port against an array-based reference model.
// Directed scenarios first, then randomized traffic.
module tb_reg_file_bank;

  localparam int          N   = 4;
  localparam logic [31:0] RV  = 32'h5;
  // Config i uses bit i: 0 = comb/bypass, 1 = comb/R0 zero/no bypass,
  // 2 = registered/bypass, 3 = registered/R0 zero/bypass.
  localparam logic [N-1:0] R0Z  = 4'b1010;
  localparam logic [N-1:0] BYP  = 4'b1101;
  localparam logic [N-1:0] RREG = 4'b1100;

  logic        clk = 1'b0;
  logic        clr, we, ba_mode, re;
  logic [3:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [31:0] rda [N];
  logic [31:0] rdb [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    reg_file_bank #(
      .WIDTH     (32),
      .DEPTH     (16),
      .RESET_VAL (RV),
      .R0_ZERO   (R0Z[g]),
      .BYPASS    (BYP[g]),
      .READ_REG  (RREG[g])
    ) u_dut (
      .clk     (clk),
      .clr     (clr),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .ba_mode (ba_mode),
      .re      (re),
      .rdata_a (rda[g]),
      .rdata_b (rdb[g])
    );
  end

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference state: register contents and registered-read outputs per configuration.
  logic [31:0] mem  [N][16];
  logic [31:0] m_ra [N];
  logic [31:0] m_rb [N];
  bit          model_ok = 1'b0;
  logic [31:0] obs_a [N];
  logic [31:0] obs_b [N];

  function automatic logic [31:0] model_read(input int i, input bit port_a, input logic [3:0] addr);
    if (port_a && ba_mode && addr == 4'd0) return 32'h0;
    if (R0Z[i] && addr == 4'd0) return 32'h0;
    if (BYP[i] && we && addr == waddr && !(R0Z[i] && waddr == 4'd0)) return wdata;
    return mem[i][addr];
  endfunction

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s cfg%0d observed=%h expected=%h", tag, i, obs, exp);
  endtask

  task automatic cycle(input logic c, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] a, input logic [3:0] b, input logic ba, input logic r);
    logic [31:0] nra [N];
    logic [31:0] nrb [N];
    clr = c; we = w; waddr = wa; wdata = wd;
    raddr_a = a; raddr_b = b; ba_mode = ba; re = r;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      obs_a[i] = rda[i];
      obs_b[i] = rdb[i];
      if (model_ok) begin
        check("model_rdata_a", i, rda[i], RREG[i] ? m_ra[i] : model_read(i, 1'b1, raddr_a));
        check("model_rdata_b", i, rdb[i], RREG[i] ? m_rb[i] : model_read(i, 1'b0, raddr_b));
      end
    end
    // Next registered outputs use this cycle's inputs and pre-edge contents.
    for (int i = 0; i < N; i++) begin
      nra[i] = m_ra[i];
      nrb[i] = m_rb[i];
      if (clr) begin
        nra[i] = 32'h0;
        nrb[i] = 32'h0;
      end else if (re) begin
        nra[i] = model_read(i, 1'b1, raddr_a);
        nrb[i] = model_read(i, 1'b0, raddr_b);
      end
    end
    for (int i = 0; i < N; i++) begin
      m_ra[i] = nra[i];
      m_rb[i] = nrb[i];
      if (clr) begin
        for (int k = 0; k < 16; k++) mem[i][k] = (R0Z[i] && k == 0) ? 32'h0 : RV;
      end else if (we && !(R0Z[i] && waddr == 4'd0)) begin
        mem[i][waddr] = wdata;
      end
    end
    if (clr) model_ok = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] wa;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [31:0] wd;
    clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; ba_mode = 1'b0; re = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then every non-zero register holds RESET_VAL.
    cycle(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
    for (int j = 1; j < 16; j++) begin
      cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'(j), 4'(j), 1'b0, 1'b1);
      check("reset_val", 0, obs_a[0], 32'h5);
    end
    cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b1);
    check("r0_after_reset", 0, obs_a[0], 32'h5);
    check("r0_zero_reset", 1, obs_a[1], 32'h0);

    // Write then read; neighbour keeps its reset value.
    cycle(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd4, 1'b0, 1'b1);
    check("wr_rd_a", 0, obs_a[0], 32'hDEAD_BEEF);
    check("wr_rd_b", 0, obs_b[0], 32'h5);
    check("wr_rd_nobyp", 1, obs_a[1], 32'hDEAD_BEEF);
    // Registered read shows data one edge later, then holds while re is low.
    cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd5, 4'd5, 1'b0, 1'b0);
    check("rreg_latency_a", 2, obs_a[2], 32'hDEAD_BEEF);
    check("rreg_latency_b", 2, obs_b[2], 32'h5);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd6, 4'd6, 1'b0, 1'b0);
    check("rreg_hold", 2, obs_a[2], 32'hDEAD_BEEF);

    // Same-cycle write and read of r7.
    cycle(1'b0, 1'b1, 4'd7, 32'h1234, 4'd7, 4'd7, 1'b0, 1'b1);
    check("bypass_a", 0, obs_a[0], 32'h1234);
    check("bypass_b", 0, obs_b[0], 32'h1234);
    check("no_bypass_old", 1, obs_a[1], 32'h5);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd7, 4'd7, 1'b0, 1'b0);
    check("rreg_bypass_a", 2, obs_a[2], 32'h1234);
    check("rreg_bypass_b", 2, obs_b[2], 32'h1234);
    check("no_bypass_new", 1, obs_a[1], 32'h1234);

    // R0 write with BA mode on port A.
    cycle(1'b0, 1'b1, 4'd0, 32'hAA, 4'd1, 4'd1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1);
    check("ba_zero_a", 0, obs_a[0], 32'h0);
    check("r0_written_b", 0, obs_b[0], 32'hAA);
    check("r0z_a", 1, obs_a[1], 32'h0);
    check("r0z_b", 1, obs_b[1], 32'h0);

    // Clear and write together: clear wins, registered outputs drop to zero.
    cycle(1'b1, 1'b1, 4'd2, 32'hFF, 4'd2, 4'd2, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'd2, 4'd2, 1'b0, 1'b0);
    check("clr_beats_we", 0, obs_a[0], 32'h5);
    check("clr_rreg_b", 2, obs_b[2], 32'h0);
    check("clr_rreg_a", 3, obs_a[3], 32'h0);

    // Random traffic with frequent address collisions.
    repeat (400) begin
      wa = 4'($urandom_range(0, 15));
      wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), wa, wd, ra, rb,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
